proj_mux: RTL and testbench



---
 rtl/proj_mux_pkg.sv | 25 ++
 rtl/proj_mux_regs.sv | 97 +++++++++
 rtl/proj_mux.sv | 162 ++++++++++++++++
 tb/tb_proj_mux.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proj_mux_pkg.sv
// Shared types and register map for the multi-project pad multiplexer.
package proj_mux_pkg;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_RESET = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } mux_state_t;

   localparam logic [31:0] CTRL_OFS   = 32'h0000_0000;
   localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

   localparam int CTRL_EN_BIT      = 8;
   localparam int STATUS_STATE_LSB = 8;
   localparam int STATUS_BUSY_BIT  = 12;
   localparam int STATUS_ERR_BIT   = 16;

   // The whole low byte is the requested project, so out-of-range values are caught
   // even when their upper bits would be truncated by the select field width.
   function automatic logic sel_valid(input logic [7:0] req, input int num_proj);
      return int'(req) < num_proj;
   endfunction

endpackage

// File: rtl/proj_mux_regs.sv
// Wishbone slave for the project mux: CTRL/STATUS decode, single-cycle acks,
// sticky selection error and the "request may have changed" pending flag.
module proj_mux_regs
   import proj_mux_pkg::*;
#(
   parameter int          NUM_PROJ  = 4,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          SEL_W     = $clog2(NUM_PROJ)
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             wbs_stb_i,
   input  logic             wbs_cyc_i,
   input  logic             wbs_we_i,
   input  logic [3:0]       wbs_sel_i,
   input  logic [31:0]      wbs_dat_i,
   input  logic [31:0]      wbs_adr_i,
   output logic             wbs_ack_o,
   output logic [31:0]      wbs_dat_o,
   input  logic [SEL_W-1:0] cur_sel,
   input  mux_state_t       state,
   input  logic             busy,
   input  logic             pend_clr,
   output logic [SEL_W-1:0] ctrl_sel,
   output logic             ctrl_en,
   output logic             pending
);

   logic        req;
   logic        wr;
   logic        hit_ctrl;
   logic        hit_status;
   logic        sel_ok;
   logic        ctrl_wr;
   logic        err;
   logic [31:0] rdata;
   logic        unused_bits;

   // Masking with the current ack guarantees an idle cycle between back-to-back acks.
   assign req        = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
   assign wr         = req & wbs_we_i & wbs_sel_i[0];
   assign hit_ctrl   = (wbs_adr_i == BASE_ADDR + CTRL_OFS);
   assign hit_status = (wbs_adr_i == BASE_ADDR + STATUS_OFS);
   assign sel_ok     = sel_valid(wbs_dat_i[7:0], NUM_PROJ);
   assign ctrl_wr    = wr & hit_ctrl & sel_ok;

   assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:17], wbs_dat_i[15:9]};

   always_comb begin
      rdata = '0;
      if (hit_ctrl) begin
         rdata[SEL_W-1:0]   = ctrl_sel;
         rdata[CTRL_EN_BIT] = ctrl_en;
      end else if (hit_status) begin
         rdata[SEL_W-1:0]                = cur_sel;
         rdata[STATUS_STATE_LSB +: 2]    = state;
         rdata[STATUS_BUSY_BIT]          = busy;
         rdata[STATUS_ERR_BIT]           = err;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
      end else begin
         wbs_ack_o <= req;
         wbs_dat_o <= (req && !wbs_we_i) ? rdata : '0;
      end
   end

   // A write landing on the same edge as a load must survive, so set beats clear.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ctrl_sel <= '0;
         ctrl_en  <= 1'b0;
         err      <= 1'b0;
         pending  <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            ctrl_sel <= wbs_dat_i[SEL_W-1:0];
            ctrl_en  <= wbs_dat_i[CTRL_EN_BIT];
         end
         if (wr && hit_ctrl && !sel_ok) begin
            err <= 1'b1;
         end else if (wr && hit_status && wbs_dat_i[STATUS_ERR_BIT]) begin
            err <= 1'b0;
         end
         if (ctrl_wr) begin
            pending <= 1'b1;
         end else if (pend_clr) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/proj_mux.sv
// Multi-project host: connects one of NUM_PROJ wrapped designs to the user pads,
// sequencing every handover through drain and reset guard intervals.
module proj_mux
   import proj_mux_pkg::*;
#(
   parameter int          NUM_PROJ     = 4,
   parameter int          IO_W         = 38,
   parameter int          GUARD_CYCLES = 8,
   parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
   parameter int          SEL_W        = $clog2(NUM_PROJ)
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic                     wbs_stb_i,
   input  logic                     wbs_cyc_i,
   input  logic                     wbs_we_i,
   input  logic [3:0]               wbs_sel_i,
   input  logic [31:0]              wbs_dat_i,
   input  logic [31:0]              wbs_adr_i,
   output logic                     wbs_ack_o,
   output logic [31:0]              wbs_dat_o,
   input  logic [NUM_PROJ*IO_W-1:0] proj_io_out_i,
   input  logic [NUM_PROJ*IO_W-1:0] proj_io_oeb_i,
   output logic [NUM_PROJ-1:0]      proj_active_o,
   output logic [NUM_PROJ-1:0]      proj_rst_o,
   output logic [IO_W-1:0]          io_out,
   output logic [IO_W-1:0]          io_oeb,
   output logic                     busy_o
);

   localparam int CNT_W = $clog2(GUARD_CYCLES);

   mux_state_t          state;
   logic [CNT_W-1:0]    cnt;
   logic [SEL_W-1:0]    cur_sel;
   logic [SEL_W-1:0]    ctrl_sel;
   logic                ctrl_en;
   logic                pending;
   logic                cnt_done;
   logic                reconfig;
   logic                pend_clr;
   logic [IO_W-1:0]     run_out;
   logic [IO_W-1:0]     run_oeb;
   logic [NUM_PROJ-1:0] run_onehot;

   proj_mux_regs #(
      .NUM_PROJ  (NUM_PROJ),
      .BASE_ADDR (BASE_ADDR),
      .SEL_W     (SEL_W)
   ) u_regs (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .wbs_stb_i (wbs_stb_i),
      .wbs_cyc_i (wbs_cyc_i),
      .wbs_we_i  (wbs_we_i),
      .wbs_sel_i (wbs_sel_i),
      .wbs_dat_i (wbs_dat_i),
      .wbs_adr_i (wbs_adr_i),
      .wbs_ack_o (wbs_ack_o),
      .wbs_dat_o (wbs_dat_o),
      .cur_sel   (cur_sel),
      .state     (state),
      .busy      (busy_o),
      .pend_clr  (pend_clr),
      .ctrl_sel  (ctrl_sel),
      .ctrl_en   (ctrl_en),
      .pending   (pending)
   );

   assign cnt_done = (cnt == CNT_W'(GUARD_CYCLES - 1));
   assign reconfig = !ctrl_en || (ctrl_sel != cur_sel);
   assign pend_clr = ((state == ST_DRAIN || state == ST_RESET) && cnt_done) ||
                     (state == ST_OFF && ctrl_en);

   always_comb begin
      run_out    = '0;
      run_oeb    = '1;
      run_onehot = '0;
      for (int k = 0; k < NUM_PROJ; k++) begin
         if (cur_sel == SEL_W'(k)) begin
            run_out       = proj_io_out_i[k*IO_W +: IO_W];
            run_oeb       = proj_io_oeb_i[k*IO_W +: IO_W];
            run_onehot[k] = 1'b1;
         end
      end
   end

   // Pads default to tristate every cycle and are only driven when the next state is
   // RUN, so leaving RUN blanks them on the very same edge.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state         <= ST_OFF;
         cnt           <= '0;
         cur_sel       <= '0;
         io_out        <= '0;
         io_oeb        <= '1;
         proj_rst_o    <= '1;
         proj_active_o <= '0;
         busy_o        <= 1'b0;
      end else begin
         io_out        <= '0;
         io_oeb        <= '1;
         proj_rst_o    <= '1;
         proj_active_o <= '0;
         case (state)
            ST_OFF: begin
               if (ctrl_en) begin
                  state   <= ST_RESET;
                  cur_sel <= ctrl_sel;
                  cnt     <= '0;
                  busy_o  <= 1'b1;
               end
            end
            ST_RESET: begin
               if (cnt_done) begin
                  cnt <= '0;
                  if (pending && reconfig) begin
                     state <= ST_DRAIN;
                  end else begin
                     state         <= ST_RUN;
                     busy_o        <= 1'b0;
                     io_out        <= run_out;
                     io_oeb        <= run_oeb;
                     proj_rst_o    <= ~run_onehot;
                     proj_active_o <= run_onehot;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_RUN: begin
               if (reconfig) begin
                  state  <= ST_DRAIN;
                  cnt    <= '0;
                  busy_o <= 1'b1;
               end else begin
                  io_out        <= run_out;
                  io_oeb        <= run_oeb;
                  proj_rst_o    <= ~run_onehot;
                  proj_active_o <= run_onehot;
               end
            end
            ST_DRAIN: begin
               if (cnt_done) begin
                  cnt <= '0;
                  if (ctrl_en) begin
                     state   <= ST_RESET;
                     cur_sel <= ctrl_sel;
                  end else begin
                     state  <= ST_OFF;
                     busy_o <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= ST_OFF;
         endcase
      end
   end

endmodule

// File: tb/tb_proj_mux.sv
// Directed bench for proj_mux: register table, pad-mux table and hand-written
// handover / pending / async-reset sequences.
module tb_proj_mux;

   localparam int          NUM_PROJ = 4;
   localparam int          IO_W     = 38;
   localparam int          GUARD    = 8;
   localparam logic [31:0] BASE     = 32'h3000_0000;
   localparam logic [31:0] CTRL_A   = BASE;
   localparam logic [31:0] STAT_A   = BASE + 32'h4;
   localparam logic [31:0] UNMAP_A  = BASE + 32'h8;

   logic                     wb_clk_i;
   logic                     wb_rst_i;
   logic                     wbs_stb_i;
   logic                     wbs_cyc_i;
   logic                     wbs_we_i;
   logic [3:0]               wbs_sel_i;
   logic [31:0]              wbs_dat_i;
   logic [31:0]              wbs_adr_i;
   logic                     wbs_ack_o;
   logic [31:0]              wbs_dat_o;
   logic [NUM_PROJ*IO_W-1:0] proj_io_out_i;
   logic [NUM_PROJ*IO_W-1:0] proj_io_oeb_i;
   logic [NUM_PROJ-1:0]      proj_active_o;
   logic [NUM_PROJ-1:0]      proj_rst_o;
   logic [IO_W-1:0]          io_out;
   logic [IO_W-1:0]          io_oeb;
   logic                     busy_o;

   logic [IO_W-1:0] p_out [NUM_PROJ];
   logic [IO_W-1:0] p_oeb [NUM_PROJ];

   int checks   = 0;
   int failures = 0;
   int cycle    = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
      string       name;
   } reg_vec_t;

   typedef struct {
      logic [IO_W-1:0] out;
      logic [IO_W-1:0] oeb;
   } io_vec_t;

   reg_vec_t rv[$];
   io_vec_t  iv[$];

   proj_mux #(
      .NUM_PROJ     (NUM_PROJ),
      .IO_W         (IO_W),
      .GUARD_CYCLES (GUARD),
      .BASE_ADDR    (BASE)
   ) dut (
      .wb_clk_i      (wb_clk_i),
      .wb_rst_i      (wb_rst_i),
      .wbs_stb_i     (wbs_stb_i),
      .wbs_cyc_i     (wbs_cyc_i),
      .wbs_we_i      (wbs_we_i),
      .wbs_sel_i     (wbs_sel_i),
      .wbs_dat_i     (wbs_dat_i),
      .wbs_adr_i     (wbs_adr_i),
      .wbs_ack_o     (wbs_ack_o),
      .wbs_dat_o     (wbs_dat_o),
      .proj_io_out_i (proj_io_out_i),
      .proj_io_oeb_i (proj_io_oeb_i),
      .proj_active_o (proj_active_o),
      .proj_rst_o    (proj_rst_o),
      .io_out        (io_out),
      .io_oeb        (io_oeb),
      .busy_o        (busy_o)
   );

   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   always @(posedge wb_clk_i) cycle = cycle + 1;

   always_comb begin
      proj_io_out_i = '0;
      proj_io_oeb_i = '0;
      for (int k = 0; k < NUM_PROJ; k++) begin
         proj_io_out_i[k*IO_W +: IO_W] = p_out[k];
         proj_io_oeb_i[k*IO_W +: IO_W] = p_oeb[k];
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One Wishbone transfer; returns read data and the bench cycle number of the ack.
   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data,
                                output logic [31:0] rdata, output int ack_cyc);
      @(negedge wb_clk_i);
      wbs_stb_i = 1'b1;
      wbs_cyc_i = 1'b1;
      wbs_we_i  = we;
      wbs_sel_i = 4'hF;
      wbs_adr_i = addr;
      wbs_dat_i = data;
      ack_cyc   = -1;
      rdata     = '0;
      for (int i = 0; i < 16; i++) begin
         @(posedge wb_clk_i);
         #1;
         if (wbs_ack_o) begin
            ack_cyc = cycle;
            rdata   = wbs_dat_o;
            break;
         end
      end
      wbs_stb_i = 1'b0;
      wbs_cyc_i = 1'b0;
      wbs_we_i  = 1'b0;
      checkOutput("wb_ack_seen", 64'(ack_cyc >= 0), 64'd1);
   endtask

   // Waits for any project to reach RUN; pads must stay tristated for the whole gap.
   task automatic waitRun(input int start, output int lat, output int busy_n, output int oeb_bad);
      lat     = -1;
      busy_n  = 0;
      oeb_bad = 0;
      @(negedge wb_clk_i);
      for (int i = 0; i < 64; i++) begin
         @(negedge wb_clk_i);
         if (proj_active_o != '0) begin
            lat = cycle - start;
            break;
         end
         if (busy_o) busy_n++;
         if (io_oeb !== '1 || io_out !== '0) oeb_bad++;
      end
   endtask

   logic [31:0]     rd;
   int              a, a2, lat, busy_n, oeb_bad, bad, off_cyc;
   logic [IO_W-1:0] prev_out, prev_oeb;

   initial begin
      wb_rst_i  = 1'b1;
      wbs_stb_i = 1'b0;
      wbs_cyc_i = 1'b0;
      wbs_we_i  = 1'b0;
      wbs_sel_i = 4'h0;
      wbs_dat_i = '0;
      wbs_adr_i = '0;
      for (int k = 0; k < NUM_PROJ; k++) begin
         p_out[k] = 38'h01_0101_0101 * IO_W'(k + 1);
         p_oeb[k] = '0;
      end

      rv.push_back('{1'b0, STAT_A,  32'h0,        32'h0,       "status_reset"});
      rv.push_back('{1'b0, CTRL_A,  32'h0,        32'h0,       "ctrl_reset"});
      rv.push_back('{1'b1, UNMAP_A, 32'hFFFF_FFFF, 32'h0,      "wr_unmapped"});
      rv.push_back('{1'b0, UNMAP_A, 32'h0,        32'h0,       "unmapped_read"});
      rv.push_back('{1'b0, CTRL_A,  32'h0,        32'h0,       "ctrl_after_unmapped_wr"});
      rv.push_back('{1'b1, CTRL_A,  32'h105,      32'h0,       "wr_bad_sel"});
      rv.push_back('{1'b0, CTRL_A,  32'h0,        32'h0,       "ctrl_after_bad_sel"});
      rv.push_back('{1'b0, STAT_A,  32'h0,        32'h1_0000,  "err_set"});
      rv.push_back('{1'b1, STAT_A,  32'h1_0000,   32'h0,       "wr_err_clear"});
      rv.push_back('{1'b0, STAT_A,  32'h0,        32'h0,       "err_cleared"});
      rv.push_back('{1'b1, CTRL_A,  32'h003,      32'h0,       "wr_sel3_off"});
      rv.push_back('{1'b0, CTRL_A,  32'h0,        32'h003,     "ctrl_sel3_off"});
      rv.push_back('{1'b0, STAT_A,  32'h0,        32'h0,       "status_still_off"});
      rv.push_back('{1'b1, CTRL_A,  32'h000,      32'h0,       "wr_ctrl_zero"});

      iv.push_back('{38'h2A_5A5A_5A5A, 38'h00_FFFF_0000});
      iv.push_back('{38'h15_A5A5_A5A5, 38'h3F_0000_FFFF});
      iv.push_back('{38'h00_0000_0001, 38'h20_0000_0000});
      iv.push_back('{38'h3F_FFFF_FFFF, 38'h00_0000_0001});

      // Reset state
      repeat (3) @(negedge wb_clk_i);
      checkOutput("rst_io_oeb", 64'(io_oeb), 64'(38'h3F_FFFF_FFFF));
      checkOutput("rst_io_out", 64'(io_out), 64'd0);
      checkOutput("rst_proj_rst", 64'(proj_rst_o), 64'hF);
      checkOutput("rst_active", 64'(proj_active_o), 64'h0);
      checkOutput("rst_busy", 64'(busy_o), 64'd0);
      checkOutput("rst_ack", 64'(wbs_ack_o), 64'd0);
      checkOutput("rst_dat", 64'(wbs_dat_o), 64'd0);
      wb_rst_i = 1'b0;

      $display("[TB] register table");
      foreach (rv[i]) begin
         applyStimulus(rv[i].we, rv[i].addr, rv[i].data, rd, a);
         if (!rv[i].we) checkOutput(rv[i].name, 64'(rd), 64'(rv[i].exp));
         @(posedge wb_clk_i);
         #1;
         checkOutput("ack_single_pulse", 64'(wbs_ack_o), 64'd0);
      end

      $display("[TB] enable project 2");
      applyStimulus(1'b1, CTRL_A, 32'h102, rd, a);
      waitRun(a, lat, busy_n, oeb_bad);
      checkOutput("enable_latency", 64'(lat), 64'(1 + GUARD));
      checkOutput("enable_busy_cycles", 64'(busy_n), 64'(GUARD));
      checkOutput("enable_gap_pads", 64'(oeb_bad), 64'd0);
      checkOutput("active_run2", 64'(proj_active_o), 64'b0100);
      checkOutput("rst_run2", 64'(proj_rst_o), 64'b1011);
      applyStimulus(1'b0, STAT_A, 32'h0, rd, a);
      checkOutput("status_run2", 64'(rd), 64'h202);

      $display("[TB] pad mux table");
      prev_out = p_out[2];
      prev_oeb = p_oeb[2];
      foreach (iv[i]) begin
         @(negedge wb_clk_i);
         for (int k = 0; k < NUM_PROJ; k++) begin
            p_out[k] = (k == 2) ? iv[i].out : ~iv[i].out;
            p_oeb[k] = (k == 2) ? iv[i].oeb : ~iv[i].oeb;
         end
         #1;
         checkOutput("io_out_latency", 64'(io_out), 64'(prev_out));
         checkOutput("io_oeb_latency", 64'(io_oeb), 64'(prev_oeb));
         @(negedge wb_clk_i);
         checkOutput("io_out_p2", 64'(io_out), 64'(iv[i].out));
         checkOutput("io_oeb_p2", 64'(io_oeb), 64'(iv[i].oeb));
         prev_out = iv[i].out;
         prev_oeb = iv[i].oeb;
      end
      @(negedge wb_clk_i);
      for (int k = 0; k < NUM_PROJ; k++) begin
         p_out[k] = 38'h01_1111_1111 * IO_W'(k + 1);
         p_oeb[k] = '0;
      end

      $display("[TB] same-configuration write");
      applyStimulus(1'b1, CTRL_A, 32'h102, rd, a);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge wb_clk_i);
         if (busy_o || proj_active_o != 4'b0100 || io_oeb !== '0) bad++;
      end
      checkOutput("same_cfg_no_effect", 64'(bad), 64'd0);

      $display("[TB] handover 2 -> 1");
      applyStimulus(1'b1, CTRL_A, 32'h101, rd, a);
      waitRun(a, lat, busy_n, oeb_bad);
      checkOutput("handover_latency", 64'(lat), 64'(2 * GUARD + 1));
      checkOutput("handover_busy_cycles", 64'(busy_n), 64'(2 * GUARD));
      checkOutput("handover_gap_pads", 64'(oeb_bad), 64'd0);
      checkOutput("active_run1", 64'(proj_active_o), 64'b0010);
      checkOutput("rst_run1", 64'(proj_rst_o), 64'b1101);
      @(negedge wb_clk_i);
      p_out[1] = 38'h12_3456_789A;
      @(negedge wb_clk_i);
      checkOutput("io_out_p1", 64'(io_out), 64'(38'h12_3456_789A));

      $display("[TB] disable during drain");
      applyStimulus(1'b1, CTRL_A, 32'h103, rd, a);
      repeat (2) @(negedge wb_clk_i);
      applyStimulus(1'b1, CTRL_A, 32'h000, rd, a2);
      off_cyc = -1;
      bad     = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge wb_clk_i);
         if (proj_active_o != '0) bad++;
         if (!busy_o && off_cyc < 0) off_cyc = cycle - a;
      end
      checkOutput("drain_to_off_cycle", 64'(off_cyc), 64'(GUARD + 1));
      checkOutput("drain_no_run_pulse", 64'(bad), 64'd0);
      checkOutput("off_busy", 64'(busy_o), 64'd0);
      checkOutput("off_proj_rst", 64'(proj_rst_o), 64'hF);
      applyStimulus(1'b0, STAT_A, 32'h0, rd, a);
      checkOutput("status_off_sel1", 64'(rd), 64'h1);

      $display("[TB] request change during reset");
      applyStimulus(1'b1, CTRL_A, 32'h100, rd, a);
      repeat (2) @(negedge wb_clk_i);
      applyStimulus(1'b1, CTRL_A, 32'h103, rd, a2);
      waitRun(a, lat, busy_n, oeb_bad);
      checkOutput("pending_latency", 64'(lat), 64'(3 * GUARD + 1));
      checkOutput("pending_busy_cycles", 64'(busy_n), 64'(3 * GUARD - 3));
      checkOutput("pending_gap_pads", 64'(oeb_bad), 64'd0);
      checkOutput("active_run3", 64'(proj_active_o), 64'b1000);
      @(negedge wb_clk_i);
      checkOutput("io_oeb_run3", 64'(io_oeb), 64'd0);

      $display("[TB] asynchronous reset in RUN");
      @(posedge wb_clk_i);
      #3;
      wb_rst_i = 1'b1;
      #1;
      checkOutput("async_io_oeb", 64'(io_oeb), 64'(38'h3F_FFFF_FFFF));
      checkOutput("async_io_out", 64'(io_out), 64'd0);
      checkOutput("async_proj_rst", 64'(proj_rst_o), 64'hF);
      checkOutput("async_active", 64'(proj_active_o), 64'h0);
      checkOutput("async_busy", 64'(busy_o), 64'd0);
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      applyStimulus(1'b0, STAT_A, 32'h0, rd, a);
      checkOutput("status_after_async", 64'(rd), 64'h0);
      applyStimulus(1'b0, CTRL_A, 32'h0, rd, a);
      checkOutput("ctrl_after_async", 64'(rd), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
